im_frame_reader: RTL and testbench

- Read-side initiator for the image memory: streams one stored frame out of the selected image block as a valid/ready word stream.
- On a start pulse it latches the block selector and word count, then issues sequential reads from address 0.
- Absorbs the memory's fixed 1-cycle read latency and buffers words in a 2-entry FIFO, so downstream backpressure never loses data.
- Sits between the image memory and the display/processing pipeline; software programs it through the IM register file.

---
 rtl/im_pkg.sv | 29 ++
 rtl/im_fifo2.sv | 70 +++++++
 rtl/im_frame_reader.sv | 175 +++++++++++++++++
 tb/tb_im_frame_reader.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/im_pkg.sv
// -----------------------------------------------------------------------------
// im_pkg
// Shared definitions for the image-memory (IM) subsystem: default widths used
// by the memory wrapper and its initiators, the image block selector codes and
// the frame reader state encoding.
// -----------------------------------------------------------------------------
package im_pkg;

    // Default geometry: one 640x480 1-bpp frame packed into 32-bit words
    // is 9600 words; the 17-bit address space covers the largest block.
    localparam int IM_DATA_W = 32;
    localparam int IM_ADDR_W = 17;
    localparam int IM_ISEL_W = 2;

    // Image block selector codes: three ROM blocks and one RAM block.
    localparam logic [IM_ISEL_W-1:0] IM_ISEL_ROM0 = 2'd0;
    localparam logic [IM_ISEL_W-1:0] IM_ISEL_ROM1 = 2'd1;
    localparam logic [IM_ISEL_W-1:0] IM_ISEL_ROM2 = 2'd2;
    localparam logic [IM_ISEL_W-1:0] IM_ISEL_RAM  = 2'd3;

    // Frame reader sequencing.
    typedef enum logic [1:0] {
        IM_IDLE   = 2'd0,
        IM_RUN    = 2'd1,
        IM_DRAIN  = 2'd2,
        IM_FINISH = 2'd3
    } im_state_e;

endpackage

// File: rtl/im_fifo2.sv
// -----------------------------------------------------------------------------
// im_fifo2
// Two-entry register FIFO used to absorb the memory read latency in front of a
// valid/ready stream. The head entry is presented combinationally.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   push       in   write push_data (ignored when full unless popping)
//   pop        in   drop the head entry (ignored when empty)
//   flush      in   discard all entries; has priority over push/pop
//   push_data  in   W-bit write data
//   count      out  number of valid entries, 0..2
//   head_data  out  oldest entry
// -----------------------------------------------------------------------------
module im_fifo2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] push_data,
    output logic [1:0]   count,
    output logic [W-1:0] head_data
);

    logic [W-1:0] slot_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count_q != 2'd0);
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    // NOTE: registered state is always updated with non-blocking assignments
    // so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two storage slots are reset on purpose: the head drives
            // the stream data port, which must read zero out of reset.
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else if (flush) begin
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (do_push) begin
                slot_q[wr_ptr_q] <= push_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign count     = count_q;
    assign head_data = slot_q[rd_ptr_q];

endmodule

// File: rtl/im_frame_reader.sv
// -----------------------------------------------------------------------------
// im_frame_reader
// Read-side initiator for the image memory. A start pulse latches the block
// selector and word count, then sequential reads are issued from address 0.
// Read data (fixed 1-cycle latency) lands in a 2-entry FIFO whose head drives
// a valid/ready stream, so downstream backpressure never drops a word.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         1-cycle pulse, begins a frame when idle
//   abort         1-cycle pulse, cancels the current frame
//   isel_in       image block to read (latched at start)
//   frame_words   number of words to read (latched at start)
//   busy          frame in progress
//   done          1-cycle pulse after the last word is accepted
//   mem_isel      latched block selector to the memory
//   mem_r_en      memory read enable
//   mem_r_addr    memory read address
//   mem_r_data    memory read data, valid 1 cycle after mem_r_en
//   m_valid       stream word valid
//   m_data        stream word
//   m_last        final word of the frame, qualified by m_valid
//   m_ready       downstream ready
// -----------------------------------------------------------------------------
module im_frame_reader
    import im_pkg::*;
#(
    parameter int DATA_W = IM_DATA_W,
    parameter int ADDR_W = IM_ADDR_W,
    parameter int ISEL_W = IM_ISEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ISEL_W-1:0] isel_in,
    input  logic [ADDR_W:0]   frame_words,
    output logic              busy,
    output logic              done,
    output logic [ISEL_W-1:0] mem_isel,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_r_addr,
    input  logic [DATA_W-1:0] mem_r_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready
);

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    im_state_e         state_q,    state_d;
    logic [ISEL_W-1:0] isel_q,     isel_d;
    logic [ADDR_W:0]   words_q,    words_d;
    logic [ADDR_W:0]   issued_q,   issued_d;
    logic [ADDR_W:0]   acc_q,      acc_d;
    logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;
    logic              inflight_q, inflight_d;

    logic [1:0]        fifo_count;
    logic [2:0]        occupancy;
    logic              pop;
    logic              flush;
    logic              issue;

    assign pop       = m_valid && m_ready;
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};

    // A read is allowed only if its return is guaranteed a FIFO slot, counting
    // the word in flight and crediting a head leaving this very cycle.
    assign issue = (state_q == IM_RUN) && !abort && (issued_q < words_q)
                && (occupancy < (3'd2 + {2'b00, pop}));

    im_fifo2 #(
        .W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .pop       (pop),
        .flush     (flush),
        .push_data (mem_r_data),
        .count     (fifo_count),
        .head_data (m_data)
    );

    assign m_valid    = (fifo_count != 2'd0);
    assign m_last     = m_valid && (acc_q == (words_q - CNT_ONE));
    assign busy       = (state_q != IM_IDLE);
    assign mem_r_en   = issue;
    assign mem_r_addr = rd_addr_q;
    assign mem_isel   = isel_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave a value held (no latches).
        state_d    = state_q;
        isel_d     = isel_q;
        words_d    = words_q;
        issued_d   = issued_q;
        acc_d      = acc_q;
        rd_addr_d  = rd_addr_q;
        inflight_d = issue;
        flush      = 1'b0;
        done       = 1'b0;

        if (pop) begin
            acc_d = acc_q + CNT_ONE;
        end

        unique case (state_q)
            IM_IDLE: begin
                // start wins over a simultaneous abort while idle.
                if (start) begin
                    isel_d    = isel_in;
                    words_d   = frame_words;
                    issued_d  = '0;
                    acc_d     = '0;
                    rd_addr_d = '0;
                    state_d   = (frame_words == '0) ? IM_FINISH : IM_RUN;
                end
            end
            IM_RUN: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = IM_IDLE;
                end else if (issue) begin
                    rd_addr_d = rd_addr_q + ADDR_ONE;
                    issued_d  = issued_q + CNT_ONE;
                    if ((issued_q + CNT_ONE) == words_q) begin
                        state_d = IM_DRAIN;
                    end
                end
            end
            IM_DRAIN: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = IM_IDLE;
                end else if (pop && m_last) begin
                    state_d = IM_FINISH;
                end
            end
            IM_FINISH: begin
                done    = !abort;
                flush   = abort;
                state_d = IM_IDLE;
            end
            default: begin
                state_d = IM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IM_IDLE;
            isel_q     <= '0;
            words_q    <= '0;
            issued_q   <= '0;
            acc_q      <= '0;
            rd_addr_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            isel_q     <= isel_d;
            words_q    <= words_d;
            issued_q   <= issued_d;
            acc_q      <= acc_d;
            rd_addr_q  <= rd_addr_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: tb/tb_im_frame_reader.sv
// -----------------------------------------------------------------------------
// tb_im_frame_reader
// Self-checking bench for im_frame_reader. A behavioural image memory (array
// per block, 1-cycle read latency) feeds the DUT; the expected stream for a
// frame is simply words 0..n-1 of the selected block, delivered in order with
// m_last on the final one and exactly one done pulse.
// -----------------------------------------------------------------------------
module tb_im_frame_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [1:0]  isel_in;
    logic [17:0] frame_words;
    logic        busy;
    logic        done;
    logic [1:0]  mem_isel;
    logic        mem_r_en;
    logic [16:0] mem_r_addr;
    logic [31:0] mem_r_data = 32'h0;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_ready;

    im_frame_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .isel_in     (isel_in),
        .frame_words (frame_words),
        .busy        (busy),
        .done        (done),
        .mem_isel    (mem_isel),
        .mem_r_en    (mem_r_en),
        .mem_r_addr  (mem_r_addr),
        .mem_r_data  (mem_r_data),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_ready     (m_ready)
    );

    always #5 clk = ~clk;

    // Image memory contents: 4 blocks x 64 words is plenty for these frames.
    logic [31:0] mem [4][64];

    always @(posedge clk) begin
        if (mem_r_en) begin
            mem_r_data <= mem[mem_isel][mem_r_addr[5:0]];
        end
    end

    int checks = 0;
    int errors = 0;

    // Scoreboard state for the frame in progress.
    logic [1:0]  exp_isel;
    int          exp_n;
    int          rd_cnt;
    int          acc_cnt;
    int          done_cnt;
    bit          mon_on;
    bit          stall_prev;
    logic [31:0] prev_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_sb(input logic [1:0] s, input int n);
        exp_isel   = s;
        exp_n      = n;
        rd_cnt     = 0;
        acc_cnt    = 0;
        done_cnt   = 0;
        stall_prev = 1'b0;
        prev_data  = 32'h0;
    endtask

    // Wait for the falling edge and score whatever the DUT shows this cycle.
    task automatic sample();
        @(negedge clk);
        if (mon_on) begin
            check("occupancy", 64'((rd_cnt - acc_cnt) <= 2), 64'd1);
            if (mem_r_en) begin
                check("rd_addr",  64'(mem_r_addr), 64'(rd_cnt));
                check("mem_isel", 64'(mem_isel), 64'(exp_isel));
                check("rd_bound", 64'(rd_cnt < exp_n), 64'd1);
                rd_cnt++;
            end
            if (stall_prev) begin
                check("hold_valid", 64'(m_valid), 64'd1);
                check("hold_data",  64'(m_data), 64'(prev_data));
            end
            if (m_valid && m_ready) begin
                if (acc_cnt < exp_n) begin
                    check("data", 64'(m_data), 64'(mem[exp_isel][acc_cnt]));
                    check("last", 64'(m_last), 64'(acc_cnt == exp_n - 1));
                end else begin
                    check("extra_word", 64'(acc_cnt), 64'(exp_n));
                end
                acc_cnt++;
            end
            if (done) begin
                done_cnt++;
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return ((cyc % 3) == 0);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Run a complete frame; optionally pulse a conflicting start mid-frame.
    task automatic run_frame(input logic [1:0] s, input int n, input int mode, input int restart_at);
        bit seen;
        int cyc;
        clear_sb(s, n);
        mon_on      = 1'b1;
        start       = 1'b1;
        isel_in     = s;
        frame_words = 18'(n);
        m_ready     = ready_for(mode, 0);
        sample();
        advance();
        start = 1'b0;
        seen  = 1'b0;
        cyc   = 1;
        while (!seen && cyc < 500) begin
            m_ready = ready_for(mode, cyc);
            if (cyc == restart_at) begin
                start       = 1'b1;
                isel_in     = ~s;
                frame_words = 18'(n + 3);
            end else begin
                start = 1'b0;
            end
            sample();
            if (done) seen = 1'b1;
            advance();
            cyc++;
        end
        start   = 1'b0;
        m_ready = 1'b1;
        check("done_seen",  64'(seen), 64'd1);
        check("word_count", 64'(acc_cnt), 64'(n));
        check("read_count", 64'(rd_cnt), 64'(n));
        check("done_count", 64'(done_cnt), 64'd1);
        sample();
        check("idle_after", 64'(busy), 64'd0);
        advance();
    endtask

    initial begin
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 64; i++) begin
                mem[b][i] = $urandom;
            end
        end
        for (int i = 0; i < 4; i++) begin
            mem[1][i] = 32'hA0 + 32'(i);
        end

        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        isel_in     = 2'd0;
        frame_words = 18'd0;
        m_ready     = 1'b1;
        mon_on      = 1'b0;
        clear_sb(2'd0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        advance();

        // Reset state.
        sample();
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        check("rst_ren",   64'(mem_r_en), 64'd0);
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_addr",  64'(mem_r_addr), 64'd0);
        check("rst_isel",  64'(mem_isel), 64'd0);
        check("rst_data",  64'(m_data), 64'd0);
        advance();

        // Exact timing of a 4-word frame from block 1 with m_ready held high.
        clear_sb(2'd1, 4);
        mon_on      = 1'b1;
        start       = 1'b1;
        isel_in     = 2'd1;
        frame_words = 18'd4;
        m_ready     = 1'b1;
        sample();
        advance();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            sample();
            check($sformatf("t1_ren_c%0d", c),   64'(mem_r_en), 64'(c >= 1 && c <= 4));
            check($sformatf("t1_valid_c%0d", c), 64'(m_valid),  64'(c >= 3 && c <= 6));
            check($sformatf("t1_done_c%0d", c),  64'(done),     64'(c == 7));
            check($sformatf("t1_busy_c%0d", c),  64'(busy),     64'(c <= 7));
            advance();
        end
        check("t1_words", 64'(acc_cnt), 64'd4);
        check("t1_dones", 64'(done_cnt), 64'd1);

        // 8 words with m_ready stuttering 1,0,0,...
        run_frame(2'($urandom_range(0, 3)), 8, 1, -1);

        // Empty frame: no reads, no stream, a single done.
        clear_sb(2'd2, 0);
        mon_on      = 1'b1;
        start       = 1'b1;
        isel_in     = 2'd2;
        frame_words = 18'd0;
        sample();
        advance();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            sample();
            check("t0_ren",   64'(mem_r_en), 64'd0);
            check("t0_valid", 64'(m_valid), 64'd0);
            if (c >= 3) check("t0_busy", 64'(busy), 64'd0);
            advance();
        end
        check("t0_dones", 64'(done_cnt), 64'd1);

        // Abort 5 cycles into a stalled 16-word frame.
        clear_sb(2'd0, 16);
        mon_on      = 1'b1;
        m_ready     = 1'b0;
        start       = 1'b1;
        isel_in     = 2'd0;
        frame_words = 18'd16;
        sample();
        advance();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            sample();
            advance();
        end
        abort = 1'b1;
        sample();
        advance();
        abort  = 1'b0;
        mon_on = 1'b0;
        for (int c = 6; c <= 8; c++) begin
            sample();
            check("ab_valid", 64'(m_valid), 64'd0);
            check("ab_busy",  64'(busy), 64'd0);
            check("ab_ren",   64'(mem_r_en), 64'd0);
            check("ab_done",  64'(done), 64'd0);
            advance();
        end
        run_frame(2'd3, 2, 0, -1);

        // A second start mid-frame must be ignored.
        run_frame(2'd2, 10, 2, 4);

        // Randomised frames.
        for (int k = 0; k < 4; k++) begin
            run_frame(2'($urandom_range(0, 3)), $urandom_range(1, 20), $urandom_range(0, 2), -1);
        end

        // Asynchronous reset in the middle of a stalled frame.
        clear_sb(2'd3, 16);
        mon_on      = 1'b1;
        m_ready     = 1'b0;
        start       = 1'b1;
        isel_in     = 2'd3;
        frame_words = 18'd16;
        sample();
        advance();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            sample();
            advance();
        end
        mon_on = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_busy",  64'(busy), 64'd0);
        check("ar_done",  64'(done), 64'd0);
        check("ar_ren",   64'(mem_r_en), 64'd0);
        check("ar_valid", 64'(m_valid), 64'd0);
        check("ar_last",  64'(m_last), 64'd0);
        check("ar_addr",  64'(mem_r_addr), 64'd0);
        check("ar_isel",  64'(mem_isel), 64'd0);
        check("ar_data",  64'(m_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        advance();
        sample();
        check("ar_idle_busy",  64'(busy), 64'd0);
        check("ar_idle_valid", 64'(m_valid), 64'd0);
        advance();
        run_frame(2'd1, 5, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
